// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer and sync flush.
// Optional perf counters are built only when EX_MEM_PERF_EN is defined.
module ex_mem_skid #(
  parameter int unsigned PC_WIDTH      = 12,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned REGADDR_WIDTH = 3
`ifdef EX_MEM_PERF_EN
  ,
  parameter int unsigned CNT_WIDTH     = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic                     ex_mem_write,
  input  logic                     ex_branch,
  input  logic [PC_WIDTH-1:0]      ex_pc,
  input  logic [DATA_WIDTH-1:0]    ex_alu_result,
  input  logic [DATA_WIDTH-1:0]    ex_reg_data2,
  input  logic [REGADDR_WIDTH-1:0] ex_rd,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_reg_write,
  output logic                     mem_mem_read,
  output logic                     mem_mem_write,
  output logic                     mem_branch,
  output logic [PC_WIDTH-1:0]      mem_pc,
  output logic [DATA_WIDTH-1:0]    mem_alu_result,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic [REGADDR_WIDTH-1:0] mem_rd,
  output logic                     mem_fwd_en
`ifdef EX_MEM_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]     perf_stall_cnt,
  output logic [CNT_WIDTH-1:0]     perf_flush_cnt
`endif
);

  typedef struct packed {
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic                     branch;
    logic [PC_WIDTH-1:0]      pc;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [REGADDR_WIDTH-1:0] rd;
  } slot_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;
  slot_t  main_q, skid_q, ex_slot;
  logic   ex_ready_q;
  logic   acc, pop;
  logic   load_main_ex, load_main_skid, load_skid;

  assign ex_slot = '{reg_write:  ex_reg_write,
                     mem_read:   ex_mem_read,
                     mem_write:  ex_mem_write,
                     branch:     ex_branch,
                     pc:         ex_pc,
                     alu_result: ex_alu_result,
                     write_data: ex_reg_data2,
                     rd:         ex_rd};

  assign mem_valid = (state_q != EMPTY);
  assign ex_ready  = ex_ready_q;
  assign acc       = ex_valid & ex_ready_q;
  assign pop       = mem_valid & mem_ready;

  always_comb begin
    state_d        = state_q;
    load_main_ex   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d      = ONE;
            load_main_ex = 1'b1;
          end
        end
        ONE: begin
          if (acc && pop) begin
            load_main_ex = 1'b1;
          end else if (acc) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ex_ready is registered from the next state, so no combinational path from mem_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      ex_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ex_ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_ex)
        main_q <= ex_slot;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= ex_slot;
    end
  end

  assign mem_reg_write  = mem_valid & main_q.reg_write;
  assign mem_mem_read   = mem_valid & main_q.mem_read;
  assign mem_mem_write  = mem_valid & main_q.mem_write;
  assign mem_branch     = mem_valid & main_q.branch;
  assign mem_pc         = main_q.pc;
  assign mem_alu_result = main_q.alu_result;
  assign mem_write_data = main_q.write_data;
  assign mem_rd         = main_q.rd;
  assign mem_fwd_en     = mem_reg_write & (mem_rd != '0);

`ifdef EX_MEM_PERF_EN
  // Saturating counters; flush does not clear them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (mem_valid && !mem_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (flush && mem_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: a reference FIFO model of occupancy and contents,
// checked every falling edge, plus directed scenarios for back-pressure, flush, gating and reset.
module tb_ex_mem_skid;

  logic        clk = 1'b0;
  logic        reset, flush, ex_valid, ex_ready;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [11:0] ex_pc;
  logic [15:0] ex_alu_result, ex_reg_data2;
  logic [2:0]  ex_rd;
  logic        mem_valid, mem_ready;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_branch;
  logic [11:0] mem_pc;
  logic [15:0] mem_alu_result, mem_write_data;
  logic [2:0]  mem_rd;
  logic        mem_fwd_en;
`ifdef EX_MEM_PERF_EN
  logic [3:0]  perf_stall_cnt, perf_flush_cnt;
  logic [3:0]  stall_m, flush_m;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [50:0] sb_q[$];

  always #5 clk = ~clk;

  ex_mem_skid #(
    .PC_WIDTH(12),
    .DATA_WIDTH(16),
    .REGADDR_WIDTH(3)
`ifdef EX_MEM_PERF_EN
    ,
    .CNT_WIDTH(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_reg_data2(ex_reg_data2), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
    .mem_pc(mem_pc), .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_rd(mem_rd), .mem_fwd_en(mem_fwd_en)
`ifdef EX_MEM_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] pc, input logic rw, input logic [2:0] rd);
    ex_valid      = v;
    ex_pc         = pc;
    ex_reg_write  = rw;
    ex_rd         = rd;
    ex_mem_read   = 1'($urandom);
    ex_mem_write  = 1'($urandom);
    ex_branch     = 1'($urandom);
    ex_alu_result = 16'($urandom);
    ex_reg_data2  = 16'($urandom);
  endtask

  // Reference model: inputs are stable at the falling edge, so decide here what the next rising edge does.
  always @(negedge clk) begin
    int unsigned occ;
    logic [50:0] exp;
    if (reset) begin
      sb_q.delete();
`ifdef EX_MEM_PERF_EN
      stall_m = '0;
      flush_m = '0;
`endif
    end else begin
      occ = sb_q.size();
      check("mon_valid", 64'(mem_valid), 64'(occ != 0));
      check("mon_ready", 64'(ex_ready), 64'(occ < 2));
      if (occ != 0) begin
        exp = sb_q[0];
        check("mon_slot", 64'({mem_reg_write, mem_mem_read, mem_mem_write, mem_branch,
                               mem_pc, mem_alu_result, mem_write_data, mem_rd}), 64'(exp));
        check("mon_fwd", 64'(mem_fwd_en), 64'(exp[50] && (exp[2:0] != 3'd0)));
      end else begin
        check("mon_gate", 64'({mem_reg_write, mem_mem_read, mem_mem_write, mem_branch, mem_fwd_en}), 64'd0);
      end
`ifdef EX_MEM_PERF_EN
      check("mon_stall_cnt", 64'(perf_stall_cnt), 64'(stall_m));
      check("mon_flush_cnt", 64'(perf_flush_cnt), 64'(flush_m));
      if (occ != 0 && !mem_ready && stall_m != 4'hF) stall_m = stall_m + 4'd1;
      if (flush && occ != 0 && flush_m != 4'hF) flush_m = flush_m + 4'd1;
`endif
      if (flush) begin
        sb_q.delete();
      end else begin
        if (occ != 0 && mem_ready) void'(sb_q.pop_front());
        if (ex_valid && occ < 2)
          sb_q.push_back({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
                          ex_pc, ex_alu_result, ex_reg_data2, ex_rd});
      end
    end
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 12'h000, 1'b0, 3'd0);
    step();
    step();
    check("rst_valid", 64'(mem_valid), 64'd0);
    check("rst_ready", 64'(ex_ready), 64'd1);
    check("rst_pc", 64'(mem_pc), 64'd0);
    reset = 1'b0;

    // Streaming
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 12'(i), 1'b1, 3'(i));
      step();
      check("t1_ready", 64'(ex_ready), 64'd1);
      check("t1_pc", 64'(mem_pc), 64'(i));
    end
    drive(1'b0, 12'h0, 1'b0, 3'd0);
    step();

    // Back-pressure
    mem_ready = 1'b0;
    drive(1'b1, 12'h010, 1'b1, 3'd1);
    step();
    drive(1'b1, 12'h011, 1'b1, 3'd2);
    step();
    check("t2_ready", 64'(ex_ready), 64'd0);
    drive(1'b1, 12'h0FF, 1'b1, 3'd7);
    step();
    check("t2_hold_pc", 64'(mem_pc), 64'h010);
    drive(1'b0, 12'h0, 1'b0, 3'd0);
    mem_ready = 1'b1;
    step();
    check("t2_second_pc", 64'(mem_pc), 64'h011);
    step();
    step();

    // Flush in FULL, then flush in ONE alongside an accept
    mem_ready = 1'b0;
    drive(1'b1, 12'h030, 1'b1, 3'd3);
    step();
    drive(1'b1, 12'h031, 1'b1, 3'd4);
    step();
    flush = 1'b1;
    drive(1'b1, 12'h020, 1'b1, 3'd5);
    step();
    flush = 1'b0;
    drive(1'b0, 12'h0, 1'b0, 3'd0);
    check("t3_valid", 64'(mem_valid), 64'd0);
    check("t3_ctrl", 64'({mem_reg_write, mem_mem_read, mem_mem_write, mem_branch}), 64'd0);
    check("t3_ready", 64'(ex_ready), 64'd1);
    drive(1'b1, 12'h032, 1'b1, 3'd1);
    step();
    flush = 1'b1;
    drive(1'b1, 12'h020, 1'b1, 3'd5);
    step();
    flush = 1'b0;
    drive(1'b0, 12'h0, 1'b0, 3'd0);
    check("t3b_valid", 64'(mem_valid), 64'd0);
    mem_ready = 1'b1;
    step();
    step();

    // Gating and forwarding
    mem_ready = 1'b0;
    drive(1'b1, 12'h040, 1'b1, 3'd0);
    step();
    drive(1'b0, 12'h0, 1'b0, 3'd0);
    check("t4_fwd_rd0", 64'(mem_fwd_en), 64'd0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    drive(1'b1, 12'h041, 1'b1, 3'd3);
    step();
    drive(1'b0, 12'h0, 1'b0, 3'd0);
    check("t4_fwd_rd3", 64'(mem_fwd_en), 64'd1);
    mem_ready = 1'b1;
    step();
    check("t4_valid", 64'(mem_valid), 64'd0);
    check("t4_rw", 64'(mem_reg_write), 64'd0);

    // Async reset mid-cycle while FULL
    mem_ready = 1'b0;
    drive(1'b1, 12'h0A5, 1'b1, 3'd6);
    step();
    drive(1'b1, 12'h0A6, 1'b1, 3'd7);
    step();
    drive(1'b0, 12'h0, 1'b0, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_valid", 64'(mem_valid), 64'd0);
    check("t5_ready", 64'(ex_ready), 64'd1);
    check("t5_data", 64'({mem_pc, mem_alu_result, mem_write_data, mem_rd}), 64'd0);
    check("t5_ctrl", 64'({mem_reg_write, mem_mem_read, mem_mem_write, mem_branch, mem_fwd_en}), 64'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 12'h050, 1'b1, 3'd2);
    step();
    drive(1'b0, 12'h0, 1'b0, 3'd0);
    check("t5_first_valid", 64'(mem_valid), 64'd1);
    check("t5_first_pc", 64'(mem_pc), 64'h050);
    mem_ready = 1'b1;
    step();

`ifdef EX_MEM_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_ready = 1'b0;
    drive(1'b1, 12'h060, 1'b1, 3'd1);
    step();
    drive(1'b0, 12'h0, 1'b0, 3'd0);
    repeat (20) step();
    check("t6_stall_sat", 64'(perf_stall_cnt), 64'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_flush_one", 64'(perf_flush_cnt), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_flush_empty", 64'(perf_flush_cnt), 64'd1);
    mem_ready = 1'b1;
`endif

    drive(1'b0, 12'h0, 1'b0, 3'd0);
    repeat (3) step();
    check("drain", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
